// File: rtl/aes_lane_serializer.sv
// Serializes a bundle of LANES parallel AES results into one lane per cycle
// with valid/ready handshakes on both sides and a zero-bubble bundle turnover.
module aes_lane_serializer #(
    parameter int unsigned LANES = 5,
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [7:0]               in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [2:0]               out_lane,
    output logic                     out_last,
    output logic [7:0]               out_tag,
    output logic [CNT_W-1:0]         bundle_cnt,
    output logic                     busy
);

    localparam int unsigned BUNDLE_W = LANES * WIDTH;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [2:0] LAST_LANE = 3'(LANES - 1);

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [BUNDLE_W-1:0] hold;
    logic [BUNDLE_W-1:0] hold_shift;
    logic [2:0]          lane_nxt;
    logic                in_fire;
    logic                out_fire;
    logic                last_fire;

    // Handshake decode; in_ready also opens in the cycle the last lane leaves.
    assign out_valid  = (state == S_SHIFT);
    assign busy       = out_valid;
    assign out_fire   = out_valid && out_ready;
    assign last_fire  = out_fire && out_last;
    assign in_ready   = !rst && (!out_valid || last_fire);
    assign in_fire    = in_valid && in_ready;
    assign hold_shift = hold >> WIDTH;
    assign lane_nxt   = out_lane + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_fire) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_fire && !in_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Holding register shifts down one lane per accepted output, so the
    // displayed lane is always the low slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            out_data   <= '0;
            out_lane   <= 3'd0;
            out_last   <= 1'b0;
            out_tag    <= 8'd0;
            bundle_cnt <= '0;
        end else begin
            if (last_fire) begin
                bundle_cnt <= bundle_cnt + CNT_W'(1);
            end
            if (in_fire) begin
                hold     <= in_data;
                out_data <= in_data[WIDTH-1:0];
                out_lane <= 3'd0;
                out_last <= (LAST_LANE == 3'd0);
                out_tag  <= in_tag;
            end else if (out_fire && !out_last) begin
                hold     <= hold_shift;
                out_data <= hold_shift[WIDTH-1:0];
                out_lane <= lane_nxt;
                out_last <= (lane_nxt == LAST_LANE);
            end else if (last_fire) begin
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_lane_serializer.sv
// Bench for aes_lane_serializer: directed table, hand sequences for the
// multi-cycle corners, and random traffic against a lane-queue model.
module tb_aes_lane_serializer;

    localparam int unsigned LANES = 5;
    localparam int unsigned WIDTH = 128;
    localparam int unsigned BW    = LANES * WIDTH;

    typedef struct {
        logic [127:0] data;
        logic [2:0]   lane;
        logic         last;
        logic [7:0]   tag;
    } lane_t;

    typedef struct {
        logic         iv;
        logic         ordy;
        logic         e_valid;
        logic [2:0]   e_lane;
        logic         e_last;
        logic         e_ir;
        logic [15:0]  e_cnt;
        logic [127:0] e_data;
    } row_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic [7:0]    in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [2:0]    out_lane;
    logic          out_last;
    logic [7:0]    out_tag;
    logic [15:0]   bundle_cnt;
    logic          busy;

    logic          d4_in_ready;
    logic          d4_out_valid;
    logic [127:0]  d4_out_data;
    logic [2:0]    d4_out_lane;
    logic          d4_out_last;
    logic [7:0]    d4_out_tag;
    logic [3:0]    d4_bundle_cnt;
    logic          d4_busy;

    aes_lane_serializer u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
        .out_last(out_last), .out_tag(out_tag), .bundle_cnt(bundle_cnt),
        .busy(busy)
    );

    aes_lane_serializer #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(d4_out_valid),
        .out_ready(out_ready), .out_data(d4_out_data), .out_lane(d4_out_lane),
        .out_last(d4_out_last), .out_tag(d4_out_tag), .bundle_cnt(d4_bundle_cnt),
        .busy(d4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_fail;
    int          run_len;
    int          max_run;
    int unsigned m_cnt;
    lane_t       exp_q[$];
    row_t        tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of lanes still owed downstream; at most one bundle deep.
    always @(negedge clk) begin
        lane_t e;
        logic  ev;
        logic  eir;
        if (rst) begin
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_in_ready", 128'(in_ready), 128'(0));
            chk("rst_out_lane", 128'(out_lane), 128'(0));
            chk("rst_out_last", 128'(out_last), 128'(0));
            chk("rst_out_data", out_data, 128'(0));
            chk("rst_out_tag", 128'(out_tag), 128'(0));
            chk("rst_bundle_cnt", 128'(bundle_cnt), 128'(0));
            exp_q.delete();
            m_cnt   = 0;
            run_len = 0;
        end else begin
            ev  = (exp_q.size() != 0);
            eir = !ev || (exp_q.size() == 1 && out_ready);
            chk("out_valid", 128'(out_valid), 128'(ev));
            chk("busy", 128'(busy), 128'(ev));
            chk("in_ready", 128'(in_ready), 128'(eir));
            chk("bundle_cnt", 128'(bundle_cnt), 128'(m_cnt & 32'hFFFF));
            chk("bundle_cnt_w4", 128'(d4_bundle_cnt), 128'(m_cnt & 32'hF));
            if (ev) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_lane", 128'(out_lane), 128'(exp_q[0].lane));
                chk("out_last", 128'(out_last), 128'(exp_q[0].last));
                chk("out_tag", 128'(out_tag), 128'(exp_q[0].tag));
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (ev && out_ready) begin
                if (exp_q[0].last) m_cnt++;
                void'(exp_q.pop_front());
            end
            if (in_valid && eir) begin
                for (int k = 0; k < LANES; k++) begin
                    e.data = in_data[k*WIDTH +: WIDTH];
                    e.lane = 3'(k);
                    e.last = (k == LANES - 1);
                    e.tag  = in_tag;
                    exp_q.push_back(e);
                end
            end
        end
    end

    function automatic logic [BW-1:0] rnd_bundle();
        logic [BW-1:0] b;
        for (int w = 0; w < BW / 32; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [BW-1:0] idx_bundle();
        logic [BW-1:0] b;
        for (int k = 0; k < LANES; k++) b[k*WIDTH +: WIDTH] = WIDTH'(k);
        return b;
    endfunction

    task automatic offer(input logic [BW-1:0] d, input logic [7:0] t);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (in_ready && !rst) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL offer_timeout: got in_ready=0 expected accept within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (!out_valid) done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got out_valid=1 expected 0 within 60 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        max_run = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [BW-1:0] b;
        logic [BW-1:0] nb;
        n_cmp    = 0;
        n_fail   = 0;
        max_run  = 0;
        run_len  = 0;
        m_cnt    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_data  = '0;
        in_tag   = 8'd0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0, 128'd0};
        for (int r = 1; r <= 5; r++)
            tbl[r] = '{1'b0, 1'b1, 1'b1, 3'(r - 1), (r == 5), (r == 5), 16'd0, 128'(r - 1)};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 16'd1, 128'd0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single bundle, lane k holds k, full-rate drain.
        in_data = idx_bundle();
        in_tag  = 8'hA5;
        for (int r = 0; r < 7; r++) begin
            in_valid  = tbl[r].iv;
            out_ready = tbl[r].ordy;
            @(negedge clk);
            chk("tbl_valid", 128'(out_valid), 128'(tbl[r].e_valid));
            chk("tbl_in_ready", 128'(in_ready), 128'(tbl[r].e_ir));
            chk("tbl_cnt", 128'(bundle_cnt), 128'(tbl[r].e_cnt));
            if (tbl[r].e_valid) begin
                chk("tbl_lane", 128'(out_lane), 128'(tbl[r].e_lane));
                chk("tbl_last", 128'(out_last), 128'(tbl[r].e_last));
                chk("tbl_data", out_data, tbl[r].e_data);
            end
            @(posedge clk);
            #1;
        end

        // Back-to-back bundles with in_valid held.
        do_reset();
        out_ready = 1'b1;
        offer(idx_bundle(), 8'h00);
        offer(rnd_bundle(), 8'h01);
        wait_idle();
        chk("b2b_run", 128'(max_run), 128'(10));
        chk("b2b_cnt", 128'(bundle_cnt), 128'(2));

        // Backpressure at lane 2 with a new bundle pending.
        do_reset();
        b  = rnd_bundle();
        nb = rnd_bundle();
        offer(b, 8'h3C);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = nb;
        in_tag    = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_lane", 128'(out_lane), 128'(2));
            chk("bp_data", out_data, b[2*WIDTH +: WIDTH]);
            chk("bp_tag", 128'(out_tag), 128'(8'h3C));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_lane", 128'(out_lane), 128'(2));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_next_lane", 128'(out_lane), 128'(3));
        chk("bp_next_data", out_data, b[3*WIDTH +: WIDTH]);
        @(posedge clk);
        #1;
        offer(nb, 8'h77);
        @(negedge clk);
        chk("pend_lane", 128'(out_lane), 128'(0));
        chk("pend_tag", 128'(out_tag), 128'(8'h77));
        chk("pend_data", out_data, nb[WIDTH-1:0]);
        @(posedge clk);
        #1;
        wait_idle();

        // Reset asserted while lane 3 is on the output.
        do_reset();
        b = rnd_bundle();
        offer(b, 8'h11);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mid_lane", 128'(out_lane), 128'(3));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_cnt", 128'(bundle_cnt), 128'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nb  = rnd_bundle();
        offer(nb, 8'h22);
        @(negedge clk);
        chk("post_rst_lane", 128'(out_lane), 128'(0));
        chk("post_rst_data", out_data, nb[WIDTH-1:0]);
        @(posedge clk);
        #1;
        wait_idle();
        chk("post_rst_cnt", 128'(bundle_cnt), 128'(1));

        // Random traffic: upstream holds an offered bundle until accepted.
        begin
            logic acc;
            in_valid = 1'b0;
            for (int i = 0; i < 800; i++) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (!in_valid || acc) begin
                    in_valid = ($urandom % 4) != 0;
                    in_data  = rnd_bundle();
                    in_tag   = 8'($urandom);
                end
                out_ready = ($urandom % 10) < 7;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            wait_idle();
        end

        // Counter wrap on the 4-bit instance.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) offer(rnd_bundle(), 8'(i));
        wait_idle();
        chk("wrap_cnt4", 128'(d4_bundle_cnt), 128'(1));
        chk("wrap_cnt16", 128'(bundle_cnt), 128'(17));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_lane_serializer.md
AES_LANE_SERIALIZER -- requirements
Module: aes_lane_serializer

Interface
REQ-001 SHALL have parameter LANES, default 5, number of 128-bit lanes per bundle.
REQ-002 SHALL have parameter WIDTH, default 128, lane width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, width of bundle counter.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream bundle (parallel AES results) valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a bundle this cycle.
REQ-008 SHALL have port in_data  input  LANES*WIDTH  bundle; lane k = bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-009 SHALL have port in_tag  input  8  source BRAM address of the bundle.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid lane.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the lane.
REQ-012 SHALL have port out_data  output  WIDTH  current lane ciphertext.
REQ-013 SHALL have port out_lane  output  3  index of current lane, 0..LANES-1.
REQ-014 SHALL have port out_last  output  1  current lane is LANES-1.
REQ-015 SHALL have port out_tag  output  8  in_tag captured with the bundle.
REQ-016 SHALL have port bundle_cnt  output  CNT_W  bundles fully emitted.
REQ-017 SHALL have port busy  output  1  state is SHIFT.

Function
REQ-018 SHALL implement FSM with states IDLE and SHIFT.
REQ-019 Input handshake SHALL occur when in_valid && in_ready on a rising edge; bundle and tag captured into holding register.
REQ-020 in_ready SHALL be combinational: 1 in IDLE; in SHIFT, 1 only in the cycle the last lane handshakes (out_valid && out_ready && out_last); 0 otherwise.
REQ-021 Output handshake SHALL occur when out_valid && out_ready.
REQ-022 IDLE -> SHIFT on input handshake; out_valid SHALL be 1 in the next cycle with out_lane=0 (latency 1 cycle).
REQ-023 In SHIFT, each output handshake on a non-last lane SHALL advance out_lane by 1 and update out_data to the next lane next cycle.
REQ-024 Lanes SHALL be emitted in order 0,1,...,LANES-1; lane 0 = in_data[WIDTH-1:0].
REQ-025 Last-lane handshake without simultaneous input handshake SHALL return to IDLE; out_valid 0 next cycle.
REQ-026 Last-lane handshake with simultaneous input handshake SHALL stay in SHIFT, lane 0 of the new bundle valid next cycle (zero bubble).
REQ-027 While out_valid && !out_ready, out_data, out_lane, out_last, out_tag SHALL remain stable.
REQ-028 out_valid SHALL be 1 exactly when state is SHIFT; busy SHALL equal out_valid.
REQ-029 out_last SHALL be 1 iff out_valid && out_lane==LANES-1.
REQ-030 bundle_cnt SHALL increment by 1 on each last-lane handshake and wrap from 2^CNT_W-1 to 0.
REQ-031 out_data, out_lane, out_tag SHALL hold last values in IDLE; consumers ignore them when out_valid=0.
REQ-032 in_valid while in_ready=0 SHALL be ignored; upstream holds data until handshake.

Reset
REQ-033 While rst=1: state IDLE, out_valid=0, busy=0, in_ready=0, out_lane=0, out_last=0, out_data=0, out_tag=0, bundle_cnt=0.
REQ-034 rst asserted mid-bundle SHALL abandon the bundle immediately (no further lanes, bundle_cnt not incremented); first edge after release accepts a new bundle.

Verification
REQ-035 Single bundle, out_ready=1: lanes 0x..00..0x..04 (lane k = k) accepted cycle N -> lanes 0..4 out on N+1..N+5, out_last on N+5, bundle_cnt=1, in_ready=1 at N+6.
REQ-036 Back-to-back bundles, in_valid held, out_ready=1: 10 consecutive out_valid cycles, no gap, out_tag changes 0x00->0x01 at lane 0 of bundle 2, bundle_cnt=2.
REQ-037 Backpressure: out_ready=0 for 3 cycles at lane 2 -> out_data/out_lane/out_tag stable all 3 cycles, lane 3 follows one cycle after out_ready=1.
REQ-038 in_valid=1 during SHIFT before last lane -> in_ready=0, held bundle unchanged, new bundle accepted only on last-lane handshake.
REQ-039 rst pulse at lane 3 -> out_valid=0 immediately, bundle_cnt unchanged (0), next bundle starts at lane 0.
REQ-040 CNT_W=4, 17 bundles -> bundle_cnt wraps to 1.
